axil_sensor_regs: RTL and testbench

Parametrised AXI4-Lite slave register block for the sensor IP family. It provides NUM_RW read/write control registers, NUM_CH read-only sensor capture registers and one sticky status register. It adds byte strobes, error responses, decoupled write-address and write-data channels, and an interrupt on new sensor data. It sits between the PS/interconnect AXI4-Lite master and the sensor front-end logic.

---
 rtl/axil_sensor_pkg.sv | 35 +++
 rtl/axil_sensor_chan.sv | 36 +++
 rtl/axil_sensor_regs.sv | 258 +++++++++++++++++++++++++
 tb/tb_axil_sensor_regs.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_sensor_pkg.sv
// Shared constants and the register-map classifier for the sensor register block.
package axil_sensor_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Position of the interrupt enable inside the status register.
   localparam int IRQ_EN_BIT = 31;

   typedef enum logic [1:0] {
      REG_RW       = 2'd0,
      REG_RO       = 2'd1,
      REG_STATUS   = 2'd2,
      REG_UNMAPPED = 2'd3
   } reg_kind_e;

   // Map a word index onto its register class: RW block first, then the
   // sensor channels, then a single status word; anything above is a hole.
   function automatic reg_kind_e classify_idx(input int unsigned idx,
                                              input int unsigned num_rw,
                                              input int unsigned num_ch);
      reg_kind_e kind;
      if (idx < num_rw) begin
         kind = REG_RW;
      end else if (idx < num_rw + num_ch) begin
         kind = REG_RO;
      end else if (idx == num_rw + num_ch) begin
         kind = REG_STATUS;
      end else begin
         kind = REG_UNMAPPED;
      end
      return kind;
   endfunction

endpackage

// File: rtl/axil_sensor_chan.sv
// One sensor channel: captured sample plus its sticky new-data flag.
// A capture and a clear in the same cycle leave the flag set.
module axil_sensor_chan
   import axil_sensor_pkg::*;
#(
   parameter int SENSOR_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set,
   input  logic                clr,
   input  logic [SENSOR_W-1:0] din,
   output logic [SENSOR_W-1:0] data,
   output logic                new_flag
);

   logic [SENSOR_W-1:0] data_r;
   logic                flag_r;

   // Sample register and sticky flag; set has priority over clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= '0;
         flag_r <= 1'b0;
      end else if (set) begin
         data_r <= din;
         flag_r <= 1'b1;
      end else if (clr) begin
         flag_r <= 1'b0;
      end
   end

   assign data     = data_r;
   assign new_flag = flag_r;

endmodule

// File: rtl/axil_sensor_regs.sv
// AXI4-Lite slave exposing RW control registers, RO sensor captures and a
// sticky status word with an interrupt enable.
module axil_sensor_regs
   import axil_sensor_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int NUM_RW   = 4,
   parameter int NUM_CH   = 2,
   parameter int SENSOR_W = 16
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic [ADDR_W-1:0]          s_axi_awaddr,
   input  logic [2:0]                 s_axi_awprot,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   input  logic [DATA_W-1:0]          s_axi_wdata,
   input  logic [DATA_W/8-1:0]        s_axi_wstrb,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   input  logic [ADDR_W-1:0]          s_axi_araddr,
   input  logic [2:0]                 s_axi_arprot,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   output logic [DATA_W-1:0]          s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   input  logic [NUM_CH-1:0]          sensor_valid,
   input  logic [NUM_CH*SENSOR_W-1:0] sensor_data,
   output logic [NUM_RW*DATA_W-1:0]   ctrl_regs,
   output logic                       irq
);

   localparam int STRB_W   = DATA_W / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_W - ADDR_LSB;

   // Write-side holders and response.
   logic              aw_full_r;
   logic [IDX_W-1:0]  aw_idx_r;
   logic              w_full_r;
   logic [DATA_W-1:0] w_data_r;
   logic [STRB_W-1:0] w_strb_r;
   logic              bvalid_r;
   logic [1:0]        bresp_r;

   // Read-side response.
   logic              rvalid_r;
   logic [1:0]        rresp_r;
   logic [DATA_W-1:0] rdata_r;

   // Register state.
   logic [DATA_W-1:0] rw_regs_r [NUM_RW];
   logic              irq_en_r;
   logic              irq_r;

   logic [NUM_CH-1:0]   new_flag_s;
   logic [NUM_CH-1:0]   chan_clr_s;
   logic [SENSOR_W-1:0] chan_data_s [NUM_CH];

   logic              aw_hs_s;
   logic              w_hs_s;
   logic              commit_s;
   logic [IDX_W-1:0]  aw_in_idx_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [DATA_W-1:0] wr_data_s;
   logic [STRB_W-1:0] wr_strb_s;
   reg_kind_e         wr_kind_s;

   logic              ar_hs_s;
   logic [IDX_W-1:0]  rd_idx_s;
   reg_kind_e         rd_kind_s;
   logic [DATA_W-1:0] rd_data_s;
   logic [1:0]        rd_resp_s;

   logic              unused_s;

   assign unused_s = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

   // ---------------- write path ----------------
   assign s_axi_awready = !aw_full_r && !bvalid_r;
   assign s_axi_wready  = !w_full_r && !bvalid_r;
   assign aw_hs_s       = s_axi_awvalid && s_axi_awready;
   assign w_hs_s        = s_axi_wvalid && s_axi_wready;
   assign aw_in_idx_s   = s_axi_awaddr[ADDR_W-1:ADDR_LSB];

   // A beat arriving this cycle counts as held, so AW+W together commit at once.
   assign wr_idx_s  = aw_full_r ? aw_idx_r : aw_in_idx_s;
   assign wr_data_s = w_full_r ? w_data_r : s_axi_wdata;
   assign wr_strb_s = w_full_r ? w_strb_r : s_axi_wstrb;
   assign commit_s  = (aw_full_r || aw_hs_s) && (w_full_r || w_hs_s);
   assign wr_kind_s = classify_idx(32'(wr_idx_s), NUM_RW, NUM_CH);

   // Write-address holder: filled on handshake, drained on commit.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_full_r <= 1'b0;
         aw_idx_r  <= '0;
      end else if (commit_s) begin
         aw_full_r <= 1'b0;
      end else if (aw_hs_s) begin
         aw_full_r <= 1'b1;
         aw_idx_r  <= aw_in_idx_s;
      end
   end

   // Write-data holder: filled on handshake, drained on commit.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_full_r <= 1'b0;
         w_data_r <= '0;
         w_strb_r <= '0;
      end else if (commit_s) begin
         w_full_r <= 1'b0;
      end else if (w_hs_s) begin
         w_full_r <= 1'b1;
         w_data_r <= s_axi_wdata;
         w_strb_r <= s_axi_wstrb;
      end
   end

   // Write response: raised on commit, held until the master takes it.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         bvalid_r <= 1'b0;
         bresp_r  <= RESP_OKAY;
      end else if (commit_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= ((wr_kind_s == REG_RW) || (wr_kind_s == REG_STATUS)) ?
                     RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_r && s_axi_bready) begin
         bvalid_r <= 1'b0;
      end
   end

   // Byte-strobed update of RW registers and the status irq_en bit.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int r = 0; r < NUM_RW; r++) begin
            rw_regs_r[r] <= '0;
         end
         irq_en_r <= 1'b0;
      end else if (commit_s) begin
         case (wr_kind_s)
            REG_RW: begin
               for (int r = 0; r < NUM_RW; r++) begin
                  if (wr_idx_s == IDX_W'(r)) begin
                     for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb_s[b]) begin
                           rw_regs_r[r][8*b +: 8] <= wr_data_s[8*b +: 8];
                        end
                     end
                  end
               end
            end
            REG_STATUS: begin
               if (wr_strb_s[IRQ_EN_BIT/8]) begin
                  irq_en_r <= wr_data_s[IRQ_EN_BIT];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------- sensor channels ----------------
   assign rd_idx_s  = s_axi_araddr[ADDR_W-1:ADDR_LSB];
   assign ar_hs_s   = s_axi_arvalid && !rvalid_r;
   assign rd_kind_s = classify_idx(32'(rd_idx_s), NUM_RW, NUM_CH);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      assign chan_clr_s[c] = ar_hs_s && (rd_idx_s == IDX_W'(NUM_RW + c));

      axil_sensor_chan #(
         .SENSOR_W (SENSOR_W)
      ) u_chan (
         .clk      (ACLK),
         .rst      (ARESET),
         .set      (sensor_valid[c]),
         .clr      (chan_clr_s[c]),
         .din      (sensor_data[c*SENSOR_W +: SENSOR_W]),
         .data     (chan_data_s[c]),
         .new_flag (new_flag_s[c])
      );
   end

   // ---------------- read path ----------------
   // Read mux over the register map; holes answer SLVERR with zero data.
   always_comb begin
      rd_data_s = '0;
      rd_resp_s = RESP_OKAY;
      case (rd_kind_s)
         REG_RW: begin
            for (int r = 0; r < NUM_RW; r++) begin
               rd_data_s = (rd_idx_s == IDX_W'(r)) ? rw_regs_r[r] : rd_data_s;
            end
         end
         REG_RO: begin
            for (int c = 0; c < NUM_CH; c++) begin
               rd_data_s[SENSOR_W-1:0] = (rd_idx_s == IDX_W'(NUM_RW + c)) ?
                                         chan_data_s[c] : rd_data_s[SENSOR_W-1:0];
            end
         end
         REG_STATUS: begin
            rd_data_s[NUM_CH-1:0] = new_flag_s;
            rd_data_s[IRQ_EN_BIT] = irq_en_r;
         end
         default: begin
            rd_data_s = '0;
            rd_resp_s = RESP_SLVERR;
         end
      endcase
   end

   // Read response: captured on AR handshake, held until the master takes it.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rvalid_r <= 1'b0;
         rresp_r  <= RESP_OKAY;
         rdata_r  <= '0;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rresp_r  <= rd_resp_s;
         rdata_r  <= rd_data_s;
      end else if (rvalid_r && s_axi_rready) begin
         rvalid_r <= 1'b0;
      end
   end

   // Level interrupt from enabled new-data flags.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= |(new_flag_s & {NUM_CH{irq_en_r}});
      end
   end

   for (genvar r = 0; r < NUM_RW; r++) begin : g_ctrl
      assign ctrl_regs[r*DATA_W +: DATA_W] = rw_regs_r[r];
   end

   assign s_axi_arready = !rvalid_r;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = bresp_r;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rresp   = rresp_r;
   assign s_axi_rdata   = rdata_r;
   assign irq           = irq_r;

endmodule

// File: tb/tb_axil_sensor_regs.sv
// Randomized self-checking bench for axil_sensor_regs against a register-map model.
module tb_axil_sensor_regs;

   logic        aclk;
   logic        areset;
   logic [5:0]  s_axi_awaddr;
   logic [2:0]  s_axi_awprot;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [5:0]  s_axi_araddr;
   logic [2:0]  s_axi_arprot;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [1:0]  sensor_valid;
   logic [31:0] sensor_data;
   logic [127:0] ctrl_regs;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model of the architectural state.
   logic [31:0] m_rw [4];
   logic [15:0] m_sens [2];
   logic [1:0]  m_flag;
   logic        m_en;

   axil_sensor_regs dut (
      .ACLK          (aclk),
      .ARESET        (areset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .sensor_valid  (sensor_valid),
      .sensor_data   (sensor_data),
      .ctrl_regs     (ctrl_regs),
      .irq           (irq)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic m_irq();
      return |(m_flag & {2{m_en}});
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_rw[i] = 32'h0;
      m_sens[0] = 16'h0;
      m_sens[1] = 16'h0;
      m_flag = 2'b00;
      m_en = 1'b0;
   endtask

   task automatic m_write(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
      if (idx < 4'd4) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) m_rw[idx[1:0]][8*b +: 8] = d[8*b +: 8];
         end
         resp = 2'b00;
      end else if (idx == 4'd6) begin
         if (s[3]) m_en = d[31];
         resp = 2'b00;
      end else begin
         resp = 2'b10;
      end
   endtask

   // Returns {resp, data} for a read of word idx from the model.
   function automatic logic [33:0] m_read(input logic [3:0] idx);
      int k;
      if (idx < 4'd4) return {2'b00, m_rw[idx[1:0]]};
      if (idx < 4'd6) begin
         k = int'(idx) - 4;
         return {2'b00, 16'h0, m_sens[k]};
      end
      if (idx == 4'd6) return {2'b00, m_en, 29'h0, m_flag};
      return {2'b10, 32'h0};
   endfunction

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done;
      bit w_done;
      bit aw_hs;
      bit w_hs;
      int cyc;
      logic [1:0] exp_resp;
      aw_done = 1'b0;
      w_done = 1'b0;
      cyc = 0;
      while (!(aw_done && w_done) && cyc < 40) begin
         s_axi_awaddr  = addr;
         s_axi_awvalid = !aw_done && (cyc >= aw_dly);
         s_axi_wdata   = data;
         s_axi_wstrb   = strb;
         s_axi_wvalid  = !w_done && (cyc >= w_dly);
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         @(posedge aclk); #1;
         if (aw_hs) aw_done = 1'b1;
         if (w_hs) w_done = 1'b1;
         cyc++;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         check_eq("wr_handshake_timeout", 128'(cyc), 128'd0);
         return;
      end
      check_eq("bvalid_lat", 128'(s_axi_bvalid), 128'd1);
      m_write(addr[5:2], data, strb, exp_resp);
      check_eq("ctrl_regs", ctrl_regs, {m_rw[3], m_rw[2], m_rw[1], m_rw[0]});
      for (int i = 0; i < b_dly; i++) begin
         @(posedge aclk); #1;
         check_eq("b_hold", {125'd0, s_axi_bvalid, s_axi_awready, s_axi_wready}, 128'b100);
      end
      check_eq("bresp", 128'(s_axi_bresp), 128'(exp_resp));
      s_axi_bready = 1'b1;
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
      check_eq("b_clear", 128'(s_axi_bvalid), 128'd0);
   endtask

   task automatic axi_read(input logic [5:0] addr, input int rr_dly,
                           input bit cap_en, input int cap_ch, input logic [15:0] cap_val);
      logic [33:0] exp;
      logic irq_before;
      logic [3:0] idx;
      idx = addr[5:2];
      exp = m_read(idx);
      irq_before = m_irq();
      check_eq("arready_idle", 128'(s_axi_arready), 128'd1);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      if (cap_en) begin
         sensor_valid[cap_ch] = 1'b1;
         sensor_data[cap_ch*16 +: 16] = cap_val;
      end
      @(posedge aclk); #1;
      s_axi_arvalid = 1'b0;
      sensor_valid  = 2'b00;
      check_eq("rvalid_lat", 128'(s_axi_rvalid), 128'd1);
      check_eq("irq_lag_rd", 128'(irq), 128'(irq_before));
      if (idx == 4'd4) m_flag[0] = 1'b0;
      if (idx == 4'd5) m_flag[1] = 1'b0;
      if (cap_en) begin
         m_sens[cap_ch] = cap_val;
         m_flag[cap_ch] = 1'b1;
      end
      for (int i = 0; i < rr_dly; i++) begin
         @(posedge aclk); #1;
         check_eq("r_hold", {126'd0, s_axi_rvalid, s_axi_arready}, 128'b10);
      end
      check_eq("rdata", 128'(s_axi_rdata), 128'(exp[31:0]));
      check_eq("rresp", 128'(s_axi_rresp), 128'(exp[33:32]));
      s_axi_rready = 1'b1;
      @(posedge aclk); #1;
      s_axi_rready = 1'b0;
      check_eq("r_clear", 128'(s_axi_rvalid), 128'd0);
      check_eq("irq_after_rd", 128'(irq), 128'(m_irq()));
   endtask

   task automatic capture(input int ch, input logic [15:0] val);
      logic irq_before;
      irq_before = m_irq();
      sensor_valid[ch] = 1'b1;
      sensor_data[ch*16 +: 16] = val;
      @(posedge aclk); #1;
      sensor_valid = 2'b00;
      check_eq("irq_lag_cap", 128'(irq), 128'(irq_before));
      m_sens[ch] = val;
      m_flag[ch] = 1'b1;
      @(posedge aclk); #1;
      check_eq("irq_cap", 128'(irq), 128'(m_irq()));
   endtask

   initial begin
      logic [3:0] ridx;
      int op;
      areset        = 1'b1;
      s_axi_awaddr  = 6'h0;
      s_axi_awprot  = 3'h0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = 32'h0;
      s_axi_wstrb   = 4'h0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      s_axi_araddr  = 6'h0;
      s_axi_arprot  = 3'h0;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      sensor_valid  = 2'b00;
      sensor_data   = 32'h0;
      m_reset();
      repeat (3) @(posedge aclk);
      #1;
      areset = 1'b0;
      @(posedge aclk); #1;

      // Reset state
      check_eq("rst_ready", {125'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 128'b111);
      check_eq("rst_valid", {126'd0, s_axi_bvalid, s_axi_rvalid}, 128'b00);
      check_eq("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 128'd0);
      check_eq("rst_ctrl", ctrl_regs, 128'd0);
      check_eq("rst_irq", 128'(irq), 128'd0);

      // W first, AW three cycles later, partial strobe on a zero register
      axi_write(6'h04, 32'hAABBCCDD, 4'b0101, 3, 0, 0);
      axi_read(6'h04, 0, 1'b0, 0, 16'h0);

      // Full-word writes then readback
      for (int i = 0; i < 4; i++) axi_write(6'(i*4), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) axi_read(6'(i*4), 0, 1'b0, 0, 16'h0);

      // Capture on channel 1, status, data, status cleared
      capture(1, 16'h1234);
      axi_read(6'h18, 0, 1'b0, 0, 16'h0);
      axi_read(6'h14, 1, 1'b0, 0, 16'h0);
      axi_read(6'h18, 0, 1'b0, 0, 16'h0);

      // Interrupt path
      axi_write(6'h18, 32'h80000000, 4'hF, 0, 0, 0);
      capture(0, 16'h5A5A);
      axi_read(6'h10, 0, 1'b0, 0, 16'h0);

      // Error responses
      axi_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 1, 0);
      axi_write(6'h3C, 32'h12345678, 4'hF, 1, 0, 0);
      axi_read(6'h3C, 0, 1'b0, 0, 16'h0);
      axi_read(6'h10, 0, 1'b0, 0, 16'h0);

      // Capture and clear-on-read of the same channel in one cycle
      axi_read(6'h10, 0, 1'b1, 0, 16'hBEEF);
      axi_read(6'h18, 0, 1'b0, 0, 16'h0);

      // Randomized mix
      for (int i = 0; i < 250; i++) begin
         op = $urandom_range(0, 3);
         ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
         case (op)
            0: axi_write({ridx, 2'($urandom_range(0, 3))}, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            1: axi_read({ridx, 2'($urandom_range(0, 3))}, $urandom_range(0, 2),
                        ($urandom_range(0, 3) == 0), $urandom_range(0, 1), 16'($urandom));
            2: capture($urandom_range(0, 1), 16'($urandom));
            default: begin
               @(posedge aclk); #1;
               check_eq("irq_idle", 128'(irq), 128'(m_irq()));
            end
         endcase
      end

      // B held off, then async reset with both responses pending and irq high
      axi_write(6'h18, 32'h80000000, 4'b1000, 0, 0, 0);
      capture(1, 16'h0F0F);
      s_axi_araddr  = 6'h00;
      s_axi_arvalid = 1'b1;
      s_axi_awaddr  = 6'h08;
      s_axi_awvalid = 1'b1;
      s_axi_wdata   = 32'hDEADBEEF;
      s_axi_wstrb   = 4'hF;
      s_axi_wvalid  = 1'b1;
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_arvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_eq("bready_low_hold", {125'd0, s_axi_bvalid, s_axi_awready, s_axi_wready}, 128'b100);
         @(posedge aclk); #1;
      end
      check_eq("pre_rst_irq", 128'(irq), 128'd1);
      areset = 1'b1;
      #1;
      check_eq("arst_valid", {126'd0, s_axi_bvalid, s_axi_rvalid}, 128'b00);
      check_eq("arst_ready", {125'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 128'b111);
      check_eq("arst_ctrl", ctrl_regs, 128'd0);
      check_eq("arst_irq_rdata", {95'd0, irq, s_axi_rdata}, 128'd0);
      m_reset();
      @(posedge aclk); #1;
      areset = 1'b0;
      @(posedge aclk); #1;
      for (int i = 0; i < 7; i++) axi_read(6'(i*4), 0, 1'b0, 0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
